// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP divide/sqrt sequencing controller.
package fp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ROUND = 2'd2,
    WB    = 2'd3
  } divsqrt_state_t;

  localparam logic FP_OP_DIV  = 1'b0;
  localparam logic FP_OP_SQRT = 1'b1;

  // Bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}.
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_divsqrt_ctrl.sv
// Sequencer for the shared iterative FDIV.S/FSQRT.S datapath: accepts one
// operation, stalls the front end, walks the datapath through its iterations
// and rounding cycle, then writes the held result back when the normal FP
// pipeline leaves the write port free.
module fp_divsqrt_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int DIV_ITER  = 26,  // must be >= 1
  parameter int SQRT_ITER = 25   // must be >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [4:0]  issue_rd,
  input  logic [2:0]  issue_rm,
  output logic        issue_ready,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        dp_start,
  output logic        dp_op,
  output logic [2:0]  dp_rm,
  output logic        dp_iter_en,
  output logic        dp_round,
  input  logic        dp_special,
  input  logic [31:0] dp_result,
  input  logic [4:0]  dp_flags,
  input  logic        pipe_wb_valid,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_flags
);

  localparam int MAX_ITER = max_int(DIV_ITER, SQRT_ITER);
  // A single-iteration configuration still needs a 1-bit counter.
  localparam int CNT_W = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_ITER - 1);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_ITER - 1);

  divsqrt_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       rm_q, rm_d;
  logic [31:0]      data_q, data_d;
  logic [4:0]       flags_q, flags_d;

  // Next-state, counter, field latching and per-state datapath controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rm_d        = rm_q;
    data_d      = data_q;
    flags_d     = flags_q;
    issue_ready = 1'b0;
    dp_start    = 1'b0;
    dp_iter_en  = 1'b0;
    dp_round    = 1'b0;
    wb_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        issue_ready = !flush;
        if (issue_valid && !flush) begin
          state_d = BUSY;
          op_d    = issue_op;
          rd_d    = issue_rd;
          rm_d    = issue_rm;
          cnt_d   = (issue_op == FP_OP_SQRT) ? SQRT_LOAD : DIV_LOAD;
          first_d = 1'b1;
        end
      end
      BUSY: begin
        dp_iter_en = 1'b1;
        dp_start   = first_q;
        first_d    = 1'b0;
        if (flush) begin
          state_d = IDLE;
        end else if (first_q && dp_special) begin
          // Special operands resolve immediately; skip the iterations.
          state_d = ROUND;
        end else if (cnt_q == '0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ROUND: begin
        dp_round = 1'b1;
        data_d   = dp_result;
        flags_d  = dp_flags;
        state_d  = flush ? IDLE : WB;
      end
      WB: begin
        // The normal FP pipeline owns the write port when it wants it.
        wb_valid = !pipe_wb_valid && !flush;
        if (flush || wb_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latched operation fields; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      op_q    <= 1'b0;
      rd_q    <= '0;
      rm_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rm_q    <= rm_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy;
  assign dp_op     = op_q;
  assign dp_rm     = rm_q;
  assign wb_rd     = rd_q;
  assign wb_data   = data_q;
  assign wb_flags  = flags_q;

endmodule

// File: doc/fp_divsqrt_ctrl.md
# fp_divsqrt_ctrl

Sequencing controller for the iterative single-precision FDIV.S/FSQRT.S datapath in the power-optimized RV32F pipeline. It accepts one divide/sqrt operation from the EX stage and stalls younger instructions while busy. It steps the shared iterative datapath through its iterations and a rounding cycle. It then arbitrates the held result onto the FP write-back port, where the normal FP pipeline has priority. While idle, the datapath enable stays low to save power.

## Interface
- `DIV_ITER`, default 26: iteration cycles for FDIV.S.
- `SQRT_ITER`, default 25: iteration cycles for FSQRT.S.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `issue_valid` in 1: EX presents FDIV.S/FSQRT.S.
- `issue_op` in 1: 0 = div, 1 = sqrt.
- `issue_rd` in 5: destination FP register.
- `issue_rm` in 3: resolved rounding mode.
- `issue_ready` out 1: controller can accept.
- `flush` in 1: pipeline squash (taken branch in MEM).
- `stall_req` out 1: freeze IF/ID/EX.
- `busy` out 1: operation in flight.
- `dp_start` out 1: one-cycle datapath load pulse.
- `dp_op` out 1: latched op.
- `dp_rm` out 3: latched rounding mode.
- `dp_iter_en` out 1: iteration enable (clock-gate enable).
- `dp_round` out 1: rounding/normalize cycle.
- `dp_special` in 1: special operand detected (NaN, Inf, zero, div-by-zero); valid during the `dp_start` cycle.
- `dp_result` in 32: datapath result; valid during `dp_round`.
- `dp_flags` in 5: fflags {NV,DZ,OF,UF,NX}; valid during `dp_round`.
- `pipe_wb_valid` in 1: normal FP pipeline writes this cycle.
- `wb_valid` out 1: controller writes the FP register file.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: result.
- `wb_flags` out 5: flags to accumulate into fflags.

## Operation
- States: IDLE, BUSY, ROUND, WB.
- IDLE:
  - `issue_ready = !flush`.
  - On `issue_valid && issue_ready`: latch op/rd/rm, load `cnt = (op ? SQRT_ITER : DIV_ITER) - 1`, go to BUSY.
- BUSY:
  - `dp_iter_en = 1`.
  - `dp_start = 1` in the first BUSY cycle only.
  - If `dp_special` is high in that cycle, go to ROUND next.
  - Otherwise decrement `cnt` each cycle; at `cnt == 0` go to ROUND.
- ROUND:
  - `dp_round = 1` for one cycle.
  - Capture `dp_result` → `wb_data` and `dp_flags` → `wb_flags`.
  - Go to WB.
- WB:
  - `wb_valid = !pipe_wb_valid`, combinational; the pipeline wins contention.
  - When `wb_valid = 1`, go to IDLE.
  - `wb_rd`, `wb_data` and `wb_flags` stay stable throughout WB.
- `stall_req = busy = (state != IDLE)`.
- `issue_valid` outside IDLE is ignored; no second accept.
- `flush` in BUSY, ROUND or WB:
  - Next state is IDLE; no `wb_valid` is produced.
  - `dp_iter_en` drops next cycle.
  - A flush in WB also suppresses `wb_valid` in that same cycle.
- `flush` together with `issue_valid` in IDLE: not accepted.
- Counter width is `$clog2(max(DIV_ITER,SQRT_ITER))`. Both parameters must be ≥1. No wrap: the counter is only loaded and decremented.

## Timing
- Reset: state IDLE, counter 0, and every output 0 except `issue_ready` (1 after reset, subject to `flush`). Covered outputs: `dp_*`, `wb_*`, `stall_req`, `busy`. Latched fields are cleared.
- Reset mid-operation aborts at the next edge with no write-back.
- Accept at edge T; `dp_start` is high during cycle T+1.
- BUSY lasts N cycles (N = DIV_ITER or SQRT_ITER), or 1 cycle if special.
- ROUND is cycle T+N+1.
- Earliest `wb_valid` is cycle T+N+2 (special: T+3).
- Each cycle of `pipe_wb_valid` during WB adds one cycle.
- Back-to-back: a new accept is possible in the cycle after `wb_valid`.
- `dp_iter_en` is never high outside BUSY.

## Structure
- Shared package `fp_ctrl_pkg` holds:
  - state enum `divsqrt_state_t` (IDLE, BUSY, ROUND, WB);
  - op constants `FP_OP_DIV = 0`, `FP_OP_SQRT = 1`;
  - fflags bit indices NV=4, DZ=3, OF=2, UF=1, NX=0;
  - rm encodings.
- Single module; no sub-module. Counter and output logic are inline.
- Expected size ~150–250 lines.

## Test plan
- **Div, no contention:** accept FDIV rd=7 at T, DIV_ITER=26. `dp_result = 0x3F800000` during ROUND. Expect `dp_iter_en` high T+1..T+26, `dp_round` at T+27, `wb_valid` at T+28 with rd=7, data 0x3F800000, `stall_req` high T+1..T+28.
- **Sqrt:** SQRT_ITER=25, rd=3, rm=3'b001. Expect exactly 25 `dp_iter_en` cycles, `dp_rm = 001`, `wb_valid` at T+27.
- **Special operand:** `dp_special = 1` with `dp_flags = 5'b01000` (DZ). Expect ROUND at T+2, `wb_valid` at T+3, `wb_flags = 01000`.
- **Contention:** `pipe_wb_valid` high 3 cycles on entering WB. Expect `wb_valid` delayed 3 cycles, data/rd stable; `issue_valid` asserted mid-BUSY is not accepted.
- **Flush:** `flush` in BUSY cycle 10. Expect IDLE next cycle, `dp_iter_en = 0`, no `wb_valid`, `issue_ready = 1`.
- **Flush and reset in WB:** `flush` during WB suppresses the write. `reset` mid-BUSY leaves all outputs at reset values after the next edge.
